// File: rtl/apb_bus.sv
// apb_bus: APB requester bridge turning local transfer requests into IDLE/SETUP/ACCESS APB cycles.
// Ports: PCLK/PRESETn (async, active-high) clock and reset;
//   Transfer, IN_ADDR, IN_DATA, IN_WRITE, IN_STRB: local request side;
//   OUT_RDATA, OUT_SLVERR: result of the last completed transfer;
//   PADDR, PWDATA, PWRITE, PSTRB, PENABLE, PSEL: APB requester outputs;
//   PRDATA, PREADY, PSLVERR: APB completer responses.
module apb_bus #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int STRB_WIDTH    = 4,
  parameter int SLAVES_NUM    = 2
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     Transfer,
  input  logic [ADDRESS_WIDTH-1:0] IN_ADDR,
  input  logic [DATA_WIDTH-1:0]    IN_DATA,
  input  logic                     IN_WRITE,
  input  logic [STRB_WIDTH-1:0]    IN_STRB,
  input  logic [DATA_WIDTH-1:0]    PRDATA,
  input  logic                     PREADY,
  input  logic                     PSLVERR,
  output logic [DATA_WIDTH-1:0]    OUT_RDATA,
  output logic                     OUT_SLVERR,
  output logic [ADDRESS_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0]    PWDATA,
  output logic                     PWRITE,
  output logic [STRB_WIDTH-1:0]    PSTRB,
  output logic                     PENABLE,
  output logic [SLAVES_NUM-1:0]    PSEL
);
  localparam int IDX_W = SLAVES_NUM > 1 ? $clog2(SLAVES_NUM) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     write_q, write_d;
  logic [STRB_WIDTH-1:0]    strb_q, strb_d;
  logic [SLAVES_NUM-1:0]    sel_q, sel_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic                     slverr_q, slverr_d;
  logic [IDX_W-1:0]         idx;
  logic [SLAVES_NUM-1:0]    dec_sel;
  logic [STRB_WIDTH-1:0]    in_strb;
  logic                     setup, done;
  assign idx     = IN_ADDR[ADDRESS_WIDTH-1 -: IDX_W];
  // Indices past the last completer (non-power-of-2 SLAVES_NUM) select nobody.
  assign dec_sel = SLAVES_NUM == 1 ? '1 : 32'(idx) < SLAVES_NUM ? SLAVES_NUM'(1) << idx : '0;
  assign in_strb = IN_WRITE ? IN_STRB : '0;
  assign setup   = state_q == SETUP;
  assign done    = state_q == ACCESS && PREADY;
  always_comb begin
    state_d  = state_q == IDLE  ? (Transfer ? SETUP : IDLE) :
               state_q == SETUP ? ACCESS :
               done             ? (Transfer ? SETUP : IDLE) : ACCESS;
    addr_d   = setup ? IN_ADDR : addr_q;
    wdata_d  = setup ? IN_DATA : wdata_q;
    write_d  = setup ? IN_WRITE : write_q;
    strb_d   = setup ? in_strb : strb_q;
    sel_d    = setup ? dec_sel : sel_q;
    rdata_d  = done && !write_q ? PRDATA : rdata_q;
    slverr_d = done ? PSLVERR : slverr_q;
  end
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      strb_q   <= '0;
      sel_q    <= '0;
      rdata_q  <= '0;
      slverr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      strb_q   <= strb_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      slverr_q <= slverr_d;
    end
  end
  // SETUP shows the live request; ACCESS and IDLE show the captured copy so wait states stay stable.
  assign PADDR      = setup ? IN_ADDR : addr_q;
  assign PWDATA     = setup ? IN_DATA : wdata_q;
  assign PWRITE     = setup ? IN_WRITE : write_q;
  assign PSTRB      = setup ? in_strb : strb_q;
  assign PSEL       = setup ? dec_sel : state_q == ACCESS ? sel_q : '0;
  assign PENABLE    = state_q == ACCESS;
  assign OUT_RDATA  = rdata_q;
  assign OUT_SLVERR = slverr_q;
endmodule

// File: tb/tb_apb_bus.sv
// tb_apb_bus: randomized scoreboard bench for the apb_bus requester bridge.
module tb_apb_bus;
  localparam int N     = 150;
  localparam int ABORT = 40;
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        write;
    logic [3:0]  strb;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } txn_t;
  logic        PCLK = 1'b0, PRESETn = 1'b1, Transfer = 1'b0;
  logic [3:0]  IN_ADDR = '0, IN_STRB = '0;
  logic [31:0] IN_DATA = '0, PRDATA = '0;
  logic        IN_WRITE = 1'b0, PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0] OUT_RDATA, PWDATA;
  logic        OUT_SLVERR, PWRITE, PENABLE;
  logic [3:0]  PADDR, PSTRB;
  logic [1:0]  PSEL;
  int          compared = 0, mismatched = 0;
  txn_t        q[$];
  apb_bus dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .Transfer(Transfer), .IN_ADDR(IN_ADDR), .IN_DATA(IN_DATA),
    .IN_WRITE(IN_WRITE), .IN_STRB(IN_STRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .OUT_RDATA(OUT_RDATA), .OUT_SLVERR(OUT_SLVERR), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PENABLE(PENABLE), .PSEL(PSEL)
  );
  always #5 PCLK = ~PCLK;
  function automatic txn_t mk(logic [3:0] a, logic [31:0] d, logic w, logic [3:0] s,
                              logic [31:0] r, logic e, int n);
    txn_t t;
    t.addr = a; t.wdata = d; t.write = w; t.strb = s; t.rdata = r; t.err = e; t.waits = n;
    return t;
  endfunction
  // Two completers split the 16-entry address space into equal halves.
  function automatic logic [1:0] esel(txn_t t);
    return 2'(1) << (t.addr / 8);
  endfunction
  function automatic logic [3:0] estrb(txn_t t);
    return t.write ? t.strb : 4'h0;
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_bus(string ph, txn_t t);
    chk({ph, "_paddr"}, 32'(PADDR), 32'(t.addr));
    chk({ph, "_pwdata"}, PWDATA, t.wdata);
    chk({ph, "_pwrite"}, 32'(PWRITE), 32'(t.write));
    chk({ph, "_pstrb"}, 32'(PSTRB), 32'(estrb(t)));
    chk({ph, "_psel"}, 32'(PSEL), 32'(esel(t)));
  endtask
  logic [31:0] exp_rd = '0;
  logic        exp_err = 1'b0, pend = 1'b0;
  txn_t        pend_t, last;
  always @(negedge PCLK) begin
    if (PRESETn) begin
      pend = 1'b0; exp_rd = '0; exp_err = 1'b0;
      last = mk(4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 0);
      chk("rst_ctrl", {20'h0, PENABLE, PSEL, PWRITE, PSTRB, PADDR}, 32'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_out", {OUT_RDATA[30:0], OUT_SLVERR} | {31'h0, OUT_RDATA[31]}, 32'h0);
    end else begin
      if (pend) begin
        exp_err = pend_t.err;
        if (!pend_t.write) exp_rd = pend_t.rdata;
        pend = 1'b0;
      end
      chk("out_rdata", OUT_RDATA, exp_rd);
      chk("out_slverr", 32'(OUT_SLVERR), 32'(exp_err));
      if (PENABLE || PSEL != 2'b00) begin
        if (q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL bus_unexpected: bus active (penable %0b psel %0b) with no request outstanding", PENABLE, PSEL);
        end else if (PENABLE) begin
          check_bus("access", q[0]);
          if (PREADY) begin
            pend_t = q.pop_front();
            pend = 1'b1;
            last = pend_t;
          end
        end else check_bus("setup", q[0]);
      end else begin
        chk("idle_hold", {23'h0, PWRITE, PSTRB, PADDR}, {23'h0, last.write, estrb(last), last.addr});
        chk("idle_pwdata", PWDATA, last.wdata);
      end
    end
  end
  task automatic drive(txn_t t);
    IN_ADDR = t.addr; IN_DATA = t.wdata; IN_WRITE = t.write; IN_STRB = t.strb;
  endtask
  initial begin
    txn_t tx[N];
    bit   issued, b2b;
    for (int i = 0; i < N; i++)
      tx[i] = mk(4'($urandom), $urandom, 1'($urandom), 4'($urandom), $urandom,
                 $urandom_range(3) == 0, $urandom_range(3));
    tx[0] = mk(4'hF, 32'd240, 1'b1, 4'hF, 32'h0, 1'b0, 0);
    tx[1] = mk(4'h1, 32'd15, 1'b1, 4'hF, 32'h0, 1'b0, 0);
    tx[2] = mk(4'hF, 32'hA5A5_0001, 1'b1, 4'h3, 32'h0, 1'b0, 3);
    tx[3] = mk(4'hF, 32'h0, 1'b0, 4'hF, 32'd240, 1'b0, 0);
    tx[4] = mk(4'h1, 32'h0, 1'b0, 4'hF, 32'd15, 1'b0, 2);
    tx[5] = mk(4'h9, 32'h1234, 1'b1, 4'hC, 32'h0, 1'b1, 1);
    tx[6] = mk(4'h2, 32'h0, 1'b0, 4'h5, 32'hDEAD_BEEF, 1'b0, 0);
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b0;
    @(posedge PCLK); #1;
    issued = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!issued) begin
        drive(tx[i]); Transfer = 1'b1; q.push_back(tx[i]);
        @(posedge PCLK); #1;
      end
      Transfer = 1'b0;
      @(posedge PCLK); #1;
      IN_ADDR = 4'($urandom); IN_DATA = $urandom; IN_WRITE = 1'($urandom); IN_STRB = 4'($urandom);
      if (i == ABORT) begin
        PREADY = 1'b0;
        @(posedge PCLK); #2;
        PRESETn = 1'b1; q.delete();
        @(posedge PCLK); #1;
        PRESETn = 1'b0; issued = 1'b0;
        continue;
      end
      repeat (tx[i].waits) begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        @(posedge PCLK); #1;
      end
      PREADY = 1'b1; PRDATA = tx[i].rdata; PSLVERR = tx[i].err;
      b2b = i < N - 1 && (i == 0 || (i != 1 && $urandom_range(1) == 1));
      if (b2b) begin
        drive(tx[i+1]); Transfer = 1'b1; q.push_back(tx[i+1]);
      end
      @(posedge PCLK); #1;
      PREADY = 1'b0; Transfer = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
      if (!b2b) repeat ($urandom_range(2)) begin
        @(posedge PCLK); #1;
      end
      issued = b2b;
    end
    repeat (3) @(posedge PCLK);
    #1;
    compared++;
    if (q.size() != 0 || pend) begin
      mismatched++;
      $display("FAIL drain: %0d requests never completed on the bus, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/apb_bus.md
# apb_bus

APB requester bridge. Converts a simple local transfer request (address, data, direction, strobes, `Transfer` flag) into APB IDLE/SETUP/ACCESS protocol toward one of `SLAVES_NUM` completers. Returns read data and slave-error status to the local side. Sits between the system-side master logic and the APB peripheral fabric.

## Interface
Parameters:
- `DATA_WIDTH`, 32: width of data buses
- `ADDRESS_WIDTH`, 4: width of address buses
- `STRB_WIDTH`, 4: byte-strobe width (DATA_WIDTH/8)
- `SLAVES_NUM`, 2: number of completers; width of `PSEL`

Ports:
- `PCLK` in 1: sole clock; everything rising-edge
- `PRESETn` in 1: asynchronous, active-high reset (asserted = 1, despite the legacy name)
- `Transfer` in 1: local request; 1 = a transfer is wanted
- `IN_ADDR` in ADDRESS_WIDTH: local address
- `IN_DATA` in DATA_WIDTH: local write data
- `IN_WRITE` in 1: 1 = write, 0 = read
- `IN_STRB` in STRB_WIDTH: local write strobes
- `PRDATA` in DATA_WIDTH: APB read data
- `PREADY` in 1: APB completer ready
- `PSLVERR` in 1: APB completer error
- `OUT_RDATA` out DATA_WIDTH: last completed read data
- `OUT_SLVERR` out 1: error status of last completed transfer
- `PADDR` out ADDRESS_WIDTH: APB address
- `PWDATA` out DATA_WIDTH: APB write data
- `PWRITE` out 1: APB direction
- `PSTRB` out STRB_WIDTH: APB strobes
- `PENABLE` out 1: APB enable
- `PSEL` out SLAVES_NUM: one-hot completer select

## Operation
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when `Transfer`=1 at a clock edge; else stay.
  - SETUP -> ACCESS unconditionally.
  - ACCESS with `PREADY`=0 -> stay (wait state). `Transfer` is ignored here; a started transfer always completes.
  - ACCESS with `PREADY`=1 -> SETUP if `Transfer`=1 (back-to-back), else IDLE.
- Slave decode: index = top clog2(SLAVES_NUM) bits of the address; `PSEL` = one-hot of index. Default config: addr 4'b1xxx -> `PSEL`=2'b10, 4'b0xxx -> 2'b01.
- Out-of-range index (non-power-of-2 `SLAVES_NUM`): `PSEL`=0. Transfer still sequences and completes on `PREADY`.
- In SETUP, `PADDR`/`PWDATA`/`PWRITE`/`PSTRB`/`PSEL` follow the `IN_*` inputs combinationally.
  - On the SETUP->ACCESS edge they are captured into holding registers.
  - Registered values drive the bus throughout ACCESS, so they are stable during wait states.
- `PSTRB` = `IN_STRB` for writes, forced 0 for reads.
- `PENABLE`=1 only in ACCESS. `PSEL`=0 in IDLE.
- In IDLE, `PADDR`/`PWDATA`/`PWRITE`/`PSTRB` hold their last registered values.
- Completion = ACCESS && `PREADY`=1 at a clock edge.
  - Read completion: `OUT_RDATA` <= `PRDATA`.
  - Any completion: `OUT_SLVERR` <= `PSLVERR`.
  - Both hold until the next relevant completion.
- `PRDATA`/`PSLVERR` are ignored outside completion.

## Timing
- Reset (async assert): state IDLE, all outputs 0 immediately. Mid-transfer reset aborts with no completion.
- Latency: `Transfer` sampled at edge N gives SETUP during cycle N..N+1 and ACCESS from edge N+1. Minimum 2 cycles per transfer.
- Back-to-back transfers: ACCESS -> SETUP with no IDLE gap; `PENABLE` drops for exactly one cycle.
- Wait states: each `PREADY`=0 cycle in ACCESS adds one cycle.
- `OUT_RDATA`/`OUT_SLVERR` valid one edge after completion.
- Requester duty: `IN_*` must be valid for the next transfer by the edge that ends its SETUP cycle.

## Test plan
- Write, no wait: reset; `Transfer`=1, addr 4'hF, data 240, write. In SETUP expect `PSEL`=2'b10, `PADDR`=F, `PWDATA`=240, `PENABLE`=0. Next cycle `PENABLE`=1. `PREADY`=1 for one edge -> completion.
- Back-to-back write: after first completion set addr 4'h1, data 15, `Transfer` held 1. Expect one cycle with `PENABLE`=0, then ACCESS with `PSEL`=2'b01, `PADDR`=1, `PWDATA`=15. Drop `Transfer` + `PREADY`=1 -> IDLE, `PENABLE`=0, `PSEL`=0.
- Write with wait: hold `PREADY`=0 for 3 cycles in ACCESS. Expect `PENABLE`=1 and stable `PADDR`/`PWDATA` throughout. Completes one edge after `PREADY`=1.
- Read, no wait / with wait: addr F, `PRDATA`=240 at completion. Then addr 1, `PRDATA`=15. Expect `OUT_RDATA`=240 then 15, held after `PREADY` drops. `PSTRB`=0 during reads.
- Slave error: `PSLVERR`=1 at completion -> `OUT_SLVERR`=1. Next clean completion -> 0.
- Reset mid-ACCESS: assert `PRESETn` -> immediate IDLE, all outputs 0. After release, a new `Transfer` starts from SETUP.
